// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath/cache types: word, instruction-address split and cache frame layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;
    localparam int IBYT_W = 2;

    // Frame tag field is sized for the widest possible tag (word address bits),
    // so one frame type serves every SETS configuration; narrower tags are zero-extended.
    localparam int FTAG_W = 30;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [FTAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-block, read-only instruction cache with a
// single-outstanding refill port and hit/miss counters.
//
// state | meaning
// IDLE  | combinational lookup; a miss latches {tag, idx} and starts a refill
// FETCH | iREN held high on miss_addr until iwait drops, then the frame is written
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, state_n;

    logic [TAG_W+IDX_W-1:0] miss_addr, miss_addr_n;
    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic [IDX_W-1:0]       fill_idx;
    logic                   hit;
    logic                   fill_en;
    logic [1:0]             unused_bytoff;

    icache_frame_t frames [SETS];
    icache_frame_t sel;

    assign req_tag       = imemaddr[31:IDX_W+2];
    assign req_idx       = imemaddr[IDX_W+1:2];
    assign unused_bytoff = imemaddr[1:0];
    assign fill_idx      = miss_addr[IDX_W-1:0];
    assign fill_tag      = miss_addr[TAG_W+IDX_W-1:IDX_W];
    assign sel           = frames[req_idx];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state     <= state_n;
            miss_addr <= miss_addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        miss_addr_n = miss_addr;
        hit         = 1'b0;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = '0;
        fill_en     = 1'b0;
        case (state)
            IDLE: begin
                hit  = imemREN && sel.valid && (sel.tag == FTAG_W'(req_tag));
                ihit = hit;
                if (hit) begin
                    imemload = sel.data;
                end
                if (imemREN && !hit) begin
                    miss_addr_n = {req_tag, req_idx};
                    state_n     = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_addr, 2'b00};
                if (!iwait) begin
                    fill_en = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Only valid bits are reset; tag/data contents are don't-care until valid is set.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i].valid <= 1'b0;
            end
        end else if (fill_en) begin
            frames[fill_idx] <= '{valid: 1'b1, tag: FTAG_W'(fill_tag), data: iload};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fill_en) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run
// against a behavioural cache model.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: resident lines keyed by index, plus one pending refill
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [29:0] m_raddr;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    logic        e_ihit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (wa == 30'h10) return 32'h2001_0005;
        return {2'b10, wa} ^ 32'h1234_5678;
    endfunction

    assign iload = iREN ? mem_word(iaddr[31:2]) : 32'hDEAD_BEEF;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_busy   = 1'b0;
        m_raddr  = '0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    // drive one cycle's inputs and compute the expected outputs for that cycle
    task automatic apply(input logic ren, input logic [31:0] addr, input logic wt);
        int i;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        #2;
        if (m_busy) begin
            e_ihit  = 1'b0;
            e_load  = '0;
            e_iren  = 1'b1;
            e_iaddr = {m_raddr, 2'b00};
        end else begin
            i       = int'(addr[5:2]);
            e_ihit  = ren && m_valid[i] && (m_tag[i] == addr[31:6]);
            e_load  = e_ihit ? m_data[i] : 32'h0;
            e_iren  = 1'b0;
            e_iaddr = '0;
        end
    endtask

    // clock edge: advance the model with the inputs that were applied
    task automatic tick();
        int i;
        @(posedge CLK);
        if (m_busy) begin
            if (!iwait) begin
                i          = int'(m_raddr[3:0]);
                m_valid[i] = 1'b1;
                m_tag[i]   = m_raddr[29:4];
                m_data[i]  = mem_word(m_raddr);
                m_misses   = m_misses + 32'd1;
                m_busy     = 1'b0;
            end
        end else if (imemREN) begin
            i = int'(imemaddr[5:2]);
            if (m_valid[i] && m_tag[i] == imemaddr[31:6]) begin
                m_hits = m_hits + 32'd1;
            end else begin
                m_busy  = 1'b1;
                m_raddr = imemaddr[31:2];
            end
        end
        #1;
    endtask

    task automatic refill(input logic [31:0] addr, input int waits);
        apply(1'b1, addr, 1'b1);
        tick();
        for (int k = 0; k <= waits; k++) begin
            apply(1'b1, addr, (k < waits));
            tick();
        end
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        iwait    = 1'b0;
        #3;
        n_checks++; if (ihit !== 1'b0)      begin n_fail++; $display("FAIL reset_ihit: got %0h expected 0", ihit); end
        n_checks++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload: got %0h expected 0", imemload); end
        n_checks++; if (iREN !== 1'b0)      begin n_fail++; $display("FAIL reset_iREN: got %0h expected 0", iREN); end
        n_checks++; if (iaddr !== 32'h0)    begin n_fail++; $display("FAIL reset_iaddr: got %0h expected 0", iaddr); end
        n_checks++; if (hit_count !== 32'h0)  begin n_fail++; $display("FAIL reset_hit_count: got %0h expected 0", hit_count); end
        n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count: got %0h expected 0", miss_count); end
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_cold_miss();
        int iren_cycles = 0;
        apply(1'b1, 32'h40, 1'b1);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_detect_ihit: got %0h expected 0", ihit); end
        n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL cold_detect_iREN: got %0h expected 0", iREN); end
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 32'h40, (k < 3));
            if (iREN === 1'b1) iren_cycles++;
            n_checks++; if (iaddr !== 32'h40) begin n_fail++; $display("FAIL cold_iaddr: got %0h expected 40", iaddr); end
            n_checks++; if (ihit !== 1'b0)    begin n_fail++; $display("FAIL cold_fetch_ihit: got %0h expected 0", ihit); end
            tick();
        end
        apply(1'b1, 32'h40, 1'b1);
        if (iREN === 1'b1) iren_cycles++;
        n_checks++; if (iren_cycles != 4)          begin n_fail++; $display("FAIL cold_iREN_cycles: got %0d expected 4", iren_cycles); end
        n_checks++; if (ihit !== 1'b1)             begin n_fail++; $display("FAIL cold_hit: got %0h expected 1", ihit); end
        n_checks++; if (imemload !== 32'h2001_0005) begin n_fail++; $display("FAIL cold_data: got %0h expected 20010005", imemload); end
        n_checks++; if (miss_count !== 32'd1)      begin n_fail++; $display("FAIL cold_miss_count: got %0d expected 1", miss_count); end
        tick();
    endtask

    task automatic test_repeat_hit();
        logic [31:0] base;
        base = m_hits;
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 32'h40, 1'b1);
            n_checks++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL repeat_ihit: got %0h expected 1", ihit); end
            n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL repeat_iREN: got %0h expected 0", iREN); end
            tick();
        end
        apply(1'b0, 32'h40, 1'b1);
        n_checks++; if (hit_count !== base + 32'd5) begin n_fail++; $display("FAIL repeat_hit_count: got %0d expected %0d", hit_count, base + 32'd5); end
        tick();
    endtask

    task automatic test_conflict();
        apply(1'b1, 32'h80, 1'b1);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_80_miss: got %0h expected 0", ihit); end
        tick();
        apply(1'b1, 32'h80, 1'b1); tick();
        apply(1'b1, 32'h80, 1'b0); tick();
        apply(1'b1, 32'h80, 1'b1);
        n_checks++; if (ihit !== 1'b1 || imemload !== mem_word(30'h20)) begin
            n_fail++; $display("FAIL conflict_80_hit: got %0h/%0h expected 1/%0h", ihit, imemload, mem_word(30'h20)); end
        tick();
        apply(1'b1, 32'h40, 1'b1);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_40_evicted: got %0h expected 0", ihit); end
        tick();
        apply(1'b1, 32'h40, 1'b0); tick();
        apply(1'b1, 32'h40, 1'b1);
        n_checks++; if (ihit !== 1'b1)        begin n_fail++; $display("FAIL conflict_40_hit: got %0h expected 1", ihit); end
        n_checks++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL conflict_miss_count: got %0d expected 3", miss_count); end
        tick();
    endtask

    task automatic test_pc_change();
        apply(1'b1, 32'h100, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(logic'(k % 2), 32'h200, (k < 3));
            n_checks++; if (iaddr !== 32'h100) begin n_fail++; $display("FAIL pcchg_iaddr: got %0h expected 100", iaddr); end
            n_checks++; if (iREN !== 1'b1 || ihit !== 1'b0) begin n_fail++; $display("FAIL pcchg_fetch: got iREN=%0h ihit=%0h expected 1/0", iREN, ihit); end
            tick();
        end
        apply(1'b1, 32'h100, 1'b1);
        n_checks++; if (ihit !== 1'b1 || imemload !== mem_word(30'h40)) begin
            n_fail++; $display("FAIL pcchg_100_hit: got %0h/%0h expected 1/%0h", ihit, imemload, mem_word(30'h40)); end
        tick();
        apply(1'b1, 32'h200, 1'b1);
        n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL pcchg_200_miss: got %0h expected 0", ihit); end
        tick();
        apply(1'b1, 32'h200, 1'b0);
        n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h200) begin n_fail++; $display("FAIL pcchg_200_fetch: got %0h/%0h expected 1/200", iREN, iaddr); end
        tick();
        apply(1'b1, 32'h200, 1'b1);
        n_checks++; if (ihit !== 1'b1 || imemload !== mem_word(30'h80)) begin
            n_fail++; $display("FAIL pcchg_200_hit: got %0h/%0h expected 1/%0h", ihit, imemload, mem_word(30'h80)); end
        tick();
    endtask

    task automatic test_reset_mid_refill();
        apply(1'b1, 32'h44, 1'b1); tick();
        apply(1'b1, 32'h44, 1'b1); tick();
        apply(1'b1, 32'h44, 1'b1);
        nRST  = 1'b0;
        iwait = 1'b0;
        #1;
        n_checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin n_fail++; $display("FAIL rstmid_outputs: got %0h/%0h expected 0/0", iREN, iaddr); end
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        apply(1'b1, 32'h44, 1'b1);
        n_checks++; if (ihit !== 1'b0)        begin n_fail++; $display("FAIL rstmid_no_frame: got %0h expected 0", ihit); end
        n_checks++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_miss_count: got %0d expected 0", miss_count); end
        tick();
        apply(1'b1, 32'h44, 1'b0); tick();
        apply(1'b1, 32'h44, 1'b1);
        n_checks++; if (ihit !== 1'b1 || miss_count !== 32'd1) begin n_fail++; $display("FAIL rstmid_refill: got %0h/%0d expected 1/1", ihit, miss_count); end
        tick();
    endtask

    task automatic test_byte_offset();
        refill(32'h40, 0);
        apply(1'b1, 32'h43, 1'b1);
        n_checks++; if (ihit !== 1'b1 || imemload !== 32'h2001_0005) begin
            n_fail++; $display("FAIL byteoff_hit: got %0h/%0h expected 1/20010005", ihit, imemload); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        r;
        logic        w;
        for (int n = 0; n < 400; n++) begin
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            r = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) != 0);
            apply(r, a, w);
            n_checks++; if (ihit !== e_ihit)      begin n_fail++; $display("FAIL rand_ihit @%0d: got %0h expected %0h", n, ihit, e_ihit); end
            n_checks++; if (imemload !== e_load)  begin n_fail++; $display("FAIL rand_imemload @%0d: got %0h expected %0h", n, imemload, e_load); end
            n_checks++; if (iREN !== e_iren)      begin n_fail++; $display("FAIL rand_iREN @%0d: got %0h expected %0h", n, iREN, e_iren); end
            n_checks++; if (iaddr !== e_iaddr)    begin n_fail++; $display("FAIL rand_iaddr @%0d: got %0h expected %0h", n, iaddr, e_iaddr); end
            n_checks++; if (hit_count !== m_hits) begin n_fail++; $display("FAIL rand_hit_count @%0d: got %0d expected %0d", n, hit_count, m_hits); end
            n_checks++; if (miss_count !== m_misses) begin n_fail++; $display("FAIL rand_miss_count @%0d: got %0d expected %0d", n, miss_count, m_misses); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_conflict();
        test_pc_change();
        test_reset_mid_refill();
        test_byte_offset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
